// File: rtl/interrupt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ctrl_pkg
// Description : Shared T-state constants, vector low bytes and the
//               interrupt sequencer state/source encodings for the 6502C.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_ctrl_pkg;

    localparam int c_tWidth = 7;

    // T-state codes presented by the PLA timing FSM
    localparam logic [c_tWidth-1:0] emptyT          = 7'h00;
    localparam logic [c_tWidth-1:0] Tone            = 7'h01;
    localparam logic [c_tWidth-1:0] Ttwo            = 7'h02;
    localparam logic [c_tWidth-1:0] T1NoBranch      = 7'h41;
    localparam logic [c_tWidth-1:0] T1BranchNoCross = 7'h21;
    localparam logic [c_tWidth-1:0] T1BranchCross   = 7'h11;

    // Vector low bytes
    localparam logic [7:0] c_vecReset = 8'hFC;
    localparam logic [7:0] c_vecNmi   = 8'hFA;
    localparam logic [7:0] c_vecIrq   = 8'hFE;

    typedef enum logic [2:0] {
        stReset   = 3'd0,
        stRstSeq  = 3'd1,
        stIdle    = 3'd2,
        stArmed   = 3'd3,
        stService = 3'd4
    } intState_t;

    typedef enum logic [0:0] {
        srcIrq = 1'b0,
        srcNmi = 1'b1
    } intSrc_t;

    // True in any cycle where the timing FSM will sample brkNow
    function automatic logic isT1(input logic [c_tWidth-1:0] t);
        return (t == Tone) || (t == T1NoBranch) ||
               (t == T1BranchNoCross) || (t == T1BranchCross);
    endfunction

    function automatic logic [7:0] srcVector(input intSrc_t s);
        return (s == srcNmi) ? c_vecNmi : c_vecIrq;
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ctrl_if
// Description : brkNow/intHandled handshake and reset/vector lines between
//               the interrupt sequencer (master) and the timing FSM (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_ctrl_if;
    import interrupt_ctrl_pkg::*;

    logic [c_tWidth-1:0] currT;
    logic                intHandled;
    logic                rstReq;
    logic                brkNow;
    logic [7:0]          vecLo;

    modport master (
        input  currT,
        input  intHandled,
        output rstReq,
        output brkNow,
        output vecLo
    );

    modport slave (
        output currT,
        output intHandled,
        input  rstReq,
        input  brkNow,
        input  vecLo
    );

endinterface
`default_nettype wire

// File: rtl/interrupt_ctrl_pin_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pin_sync_edge
// Description : Multi-stage synchroniser for an active-low asynchronous pin,
//               with a one-cycle falling-edge indication. Resets to inactive.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_sync_edge #(
    parameter int STAGES = 2
) (
    input  wire logic phi1,
    input  wire logic rst_n,
    input  wire logic i_pinN,
    output logic      o_level,
    output logic      o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the pin through the chain; keep one extra copy for edge detect
    always_ff @(posedge phi1) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pinN};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_fall  = r_prev & ~r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_ctrl
// Description : 6502C interrupt request and reset sequencer. Synchronises
//               NMI/IRQ, latches NMI edges, injects interrupt sequences via
//               brkNow and selects the vector low byte.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic       phi1,
    input  wire logic       rst_n,
    input  wire logic       RDY,
    input  wire logic       nmi_n,
    input  wire logic       irq_n,
    input  wire logic       iFlag,
    output logic            nmiPending,
    interrupt_ctrl_if.master fsm
);

    intState_t  r_state,   w_stateNext;
    intSrc_t    r_src,     w_srcNext;
    logic       r_rstReq,  w_rstReqNext;
    logic       r_brkNow,  w_brkNowNext;
    logic [7:0] r_vecLo,   w_vecLoNext;
    logic       r_nmiPending;
    logic       w_nmiClr;

    logic w_nmiLevel;
    logic w_nmiFall;
    logic w_irqLevel;
    logic w_unusedIrqFall;
    logic w_irqActive;

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_nmiSync (
        .phi1    (phi1),
        .rst_n   (rst_n),
        .i_pinN  (nmi_n),
        .o_level (w_nmiLevel),
        .o_fall  (w_nmiFall)
    );

    pin_sync_edge #(.STAGES(SYNC_STAGES)) u_irqSync (
        .phi1    (phi1),
        .rst_n   (rst_n),
        .i_pinN  (irq_n),
        .o_level (w_irqLevel),
        .o_fall  (w_unusedIrqFall)
    );

    // IRQ is a masked level, re-evaluated every cycle and never latched
    assign w_irqActive = ~w_irqLevel & ~iFlag;

    // Next-state and registered-output decode; everything holds while RDY=0
    always_comb begin
        w_stateNext  = r_state;
        w_srcNext    = r_src;
        w_rstReqNext = r_rstReq;
        w_brkNowNext = r_brkNow;
        w_vecLoNext  = r_vecLo;
        w_nmiClr     = 1'b0;
        if (RDY) begin
            case (r_state)
                stReset: begin
                    w_stateNext  = stRstSeq;
                    w_rstReqNext = 1'b0;
                    w_vecLoNext  = c_vecReset;
                end
                stRstSeq: begin
                    w_vecLoNext = c_vecReset;
                    if (fsm.intHandled) begin
                        w_stateNext = stIdle;
                        w_vecLoNext = c_vecIrq;
                    end
                end
                stIdle: begin
                    w_vecLoNext  = c_vecIrq;
                    w_brkNowNext = 1'b0;
                    if (r_nmiPending) begin
                        w_stateNext  = stArmed;
                        w_srcNext    = srcNmi;
                        w_brkNowNext = 1'b1;
                    end else if (w_irqActive) begin
                        w_stateNext  = stArmed;
                        w_srcNext    = srcIrq;
                        w_brkNowNext = 1'b1;
                    end
                end
                stArmed: begin
                    w_brkNowNext = 1'b1;
                    // A pending NMI takes over an armed IRQ, including on the
                    // commit edge, so the vector always favours NMI.
                    if (r_src == srcIrq && r_nmiPending) begin
                        w_srcNext = srcNmi;
                    end
                    if (isT1(fsm.currT)) begin
                        w_stateNext = stService;
                        w_vecLoNext = srcVector(w_srcNext);
                    end else if (r_src == srcIrq && !r_nmiPending && !w_irqActive) begin
                        // Dropping is pointless when an NMI is waiting: stay
                        // armed and let the hijack above take effect.
                        w_stateNext  = stIdle;
                        w_brkNowNext = 1'b0;
                    end
                end
                stService: begin
                    w_brkNowNext = 1'b0;
                    if (fsm.intHandled) begin
                        w_stateNext = stIdle;
                        w_vecLoNext = c_vecIrq;
                        w_nmiClr    = (r_src == srcNmi);
                    end
                end
                default: begin
                    w_stateNext  = stReset;
                    w_rstReqNext = 1'b1;
                    w_brkNowNext = 1'b0;
                    w_vecLoNext  = c_vecReset;
                end
            endcase
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge phi1) begin
        if (!rst_n) begin
            r_state  <= stReset;
            r_src    <= srcIrq;
            r_rstReq <= 1'b1;
            r_brkNow <= 1'b0;
            r_vecLo  <= c_vecReset;
        end else begin
            r_state  <= w_stateNext;
            r_src    <= w_srcNext;
            r_rstReq <= w_rstReqNext;
            r_brkNow <= w_brkNowNext;
            r_vecLo  <= w_vecLoNext;
        end
    end

    // NMI latch: runs regardless of RDY so no edge is lost; set beats clear
    always_ff @(posedge phi1) begin
        if (!rst_n) begin
            r_nmiPending <= 1'b0;
        end else if (w_nmiFall && r_state != stReset) begin
            r_nmiPending <= 1'b1;
        end else if (w_nmiClr) begin
            r_nmiPending <= 1'b0;
        end
    end

    assign nmiPending = r_nmiPending;
    assign fsm.rstReq = r_rstReq;
    assign fsm.brkNow = r_brkNow;
    assign fsm.vecLo  = r_vecLo;

endmodule
`default_nettype wire

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Interrupt request and reset sequencer for the 6502C core. It is the initiator side of the `brkNow`/`intHandled` handshake with the PLA timing FSM: it synchronises the NMI and IRQ pins, detects NMI edges, and decides when to inject an interrupt sequence. It also drives the FSM's reset request and selects the low byte of the vector address for reset, NMI, and IRQ/BRK.

## Interface
- `SYNC_STAGES`, 2, input synchroniser depth for `nmi_n` and `irq_n` (minimum 2).
- `phi1` input 1: the only clock; all state updates on posedge.
- `rst_n` input 1: synchronous, active-low reset.
- `RDY` input 1: CPU ready; while low, all sequencing state is frozen.
- `nmi_n` input 1: NMI pin, falling-edge triggered, asynchronous.
- `irq_n` input 1: IRQ pin, level-sensitive active-low, asynchronous.
- `iFlag` input 1: processor status I bit; 1 masks IRQ.
- `currT` input 7: current T-state from the timing FSM.
- `intHandled` input 1: timing FSM pulse at the end of a BRK/interrupt/reset sequence.
- `rstReq` output 1: reset request to the timing FSM.
- `brkNow` output 1: interrupt injection request to the timing FSM.
- `vecLo` output 8: vector low byte, 8'hFC reset, 8'hFA NMI, 8'hFE IRQ/BRK.
- `nmiPending` output 1: NMI edge latched and not yet serviced.

## Operation
- **States:** RESET, RSTSEQ, IDLE, ARMED, SERVICE. Source register `src` ∈ {IRQ, NMI}.
- **Reset** (`rst_n`=0 at an edge) sets:
  - state RESET, `rstReq`=1, `brkNow`=0, `vecLo`=FC, `nmiPending`=0, `src`=IRQ;
  - synchronisers to 1 (inactive).
- **RESET:** on the first edge with `rst_n`=1 and `RDY`=1, go to RSTSEQ and clear `rstReq`. If `RDY`=0, hold RESET with `rstReq`=1 so the FSM is guaranteed to see the request.
- **RSTSEQ:** `vecLo`=FC. On `intHandled`, go to IDLE.
- **NMI detection:**
  - `nmiFall` = previous synchronised value 1 and current synchronised value 0.
  - `nmiFall` sets `nmiPending`. This happens in every state except RESET, and regardless of `RDY`, so edges are never lost.
  - `nmiPending` is cleared only by `intHandled` in SERVICE with `src`=NMI.
  - If a set and a clear occur on the same edge, the set wins.
- **IRQ:** `irqActive` = (synchronised `irq_n`==0) AND NOT `iFlag`. It is not latched.
- **IDLE:**
  - `nmiPending` → ARMED with `src`=NMI.
  - Otherwise `irqActive` → ARMED with `src`=IRQ.
  - `vecLo`=FE.
- **ARMED:** `brkNow`=1.
  - If `src`=IRQ and `nmiPending` is set, switch `src` to NMI (NMI hijack).
  - If `src`=IRQ and `irqActive`=0, return to IDLE and drop `brkNow`.
  - If `currT` ∈ {`Tone`, `T1NoBranch`, `T1BranchNoCross`, `T1BranchCross`}, commit: go to SERVICE and freeze `src`.
  - Commit has priority over the IRQ-drop rule on the same edge.
- **SERVICE:** `brkNow`=1 only during the commit cycle, then 0. `vecLo` follows `src`. On `intHandled`, go to IDLE; if `src`=NMI, also clear `nmiPending`.
- **Software BRK:** never enters ARMED; `vecLo` in IDLE is FE.
- **RDY=0:** state, `src`, and all outputs except `nmiPending` are held.
- **Reset mid-sequence:** any state goes to RESET. A pending NMI is discarded.

## Timing
- **NMI latency:** let edge k be the first edge sampling `nmi_n`=0.
  - `nmiPending`=1 after edge k+2.
  - `brkNow`=1 after edge k+3, from IDLE with `RDY`=1.
- **IRQ latency:** `brkNow`=1 after edge k+2.
- **Minimum pulse widths:** NMI low ≥1 cycle. NMI high between edges ≥1 cycle.
- **Holding of `brkNow`:** it is high across the whole cycle in which `currT` is a T1-family value. This is the cycle in which the FSM samples it.
- **`vecLo`:** registered, valid from the commit edge until `intHandled`.
- **`rstReq`:** registered, high for every cycle `rst_n` is low, plus any further cycles while `RDY`=0.

## Structure
- **Shared package:** T-state constants (`Tone`, `Ttwo`, `T1NoBranch`, `T1BranchNoCross`, `T1BranchCross`, `emptyT`), vector low-byte constants, state encoding for interrupt_ctrl.
- **One sub-module:** `pin_sync_edge`, a parameterised synchroniser with falling-edge output, instantiated for NMI (uses edge) and IRQ (uses level).
- **Main module:** the FSM plus the `nmiPending`/`src` registers.

## Test plan
- Reset held 3 cycles, `RDY`=1 → `rstReq`=1 for those 3 cycles then 0; `vecLo`=FC; `intHandled` pulse → IDLE, `vecLo`=FE.
- `nmi_n` falls at edge k, `currT`=`Tone` at k+5 → `brkNow` rises after k+3; commit at k+5; `vecLo`=FA; `intHandled` clears `nmiPending`.
- `irq_n`=0, `iFlag`=1 → `brkNow` stays 0. Then `iFlag`=0 → `brkNow`=1 after one edge. `irq_n` released before any T1 → `brkNow`=0, back to IDLE.
- IRQ in ARMED, NMI edge arrives before commit → commit with `vecLo`=FA. IRQ still asserted after `intHandled` → re-armed with FE.
- `RDY`=0 for 4 cycles while ARMED with an NMI edge during the stall → state and `brkNow` held, `nmiPending`=1 at end of stall.
- NMI edge on the same edge as an NMI `intHandled` → `nmiPending` stays 1; second NMI service follows.
